// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: channel FSM state
// encodings and the channel index of each front-panel button.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE         = 2'd0,
        BTN_PRESS_WAIT   = 2'd1,
        BTN_PRESSED      = 2'd2,
        BTN_RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int BTN_FASTER = 0;
    localparam int BTN_SLOWER = 1;
    localparam int BTN_NEXT   = 2;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM with a saturating
// counter and, with BTN_AUTOREPEAT_EN defined, hold-to-repeat pulses.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_PERIOD > REPEAT_DELAY || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_PERIOD must be in 1..REPEAT_DELAY");
    end

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    btn_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       pulse_q, pulse_d;
    logic       level_q, level_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY);
    // The counter reloads below its fire point so later pulses come a
    // full REPEAT_PERIOD apart instead of a full REPEAT_DELAY.
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    wire synced = sync2_q;

    // Next-state logic for synchroniser, debounce FSM and outputs.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            BTN_IDLE: begin
                if (synced) begin
                    state_d = BTN_PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            BTN_PRESS_WAIT: begin
                if (!synced) begin
                    state_d = BTN_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = BTN_PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BTN_PRESSED: begin
                if (!synced) begin
                    state_d = BTN_RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            BTN_RELEASE_WAIT: begin
                if (synced) begin
                    state_d = BTN_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = BTN_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = BTN_IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef BTN_AUTOREPEAT_EN
        rpt_d = rpt_q;
        if (state_q == BTN_PRESSED && synced) begin
            if (rpt_q == RPT_FIRE) begin
                pulse_d = 1'b1;
                rpt_d   = RPT_RELOAD;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end else if (state_d == BTN_IDLE || state_d == BTN_PRESS_WAIT) begin
            rpt_d = '0;
        end
`endif
        level_d = (state_d == BTN_PRESSED) || (state_d == BTN_RELEASE_WAIT);
    end

    // State registers; reset drops everything to idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= BTN_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign pulse = pulse_q;
    assign level = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the faster/slower/next buttons into clean press pulses and
// held levels. Define BTN_AUTOREPEAT_EN to enable hold-to-repeat pulses.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BUTTONS     = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 25000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_pulse,
    output logic [NUM_BUTTONS-1:0] btn_level
);

    // Channels are fully independent; simultaneous pulses are left for
    // the downstream FSM to arbitrate.
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[i]),
            .pulse(btn_pulse[i]),
            .level(btn_level[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short debounce/repeat
// timings; expected pulses and levels are queued by edge number.
module tb_button_conditioner;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] btn_raw;
    logic [2:0] btn_pulse;
    logic [2:0] btn_level;

    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t pq[$];
    exp_t lq[$];

    button_conditioner #(
        .NUM_BUTTONS    (3),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_pulse(btn_pulse),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic push_p(input int c, input logic [2:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        pq.push_back(e);
    endtask

    task automatic push_l(input int c, input logic [2:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        lq.push_back(e);
    endtask

    task automatic wait_to(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [2:0] got,
                       input logic [2:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b, required %b",
                     name, edge_n, got, req);
        end
    endtask

    // Monitor: every pulse pops the pulse queue; levels checked when due.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (btn_pulse !== 3'b000) begin
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected at edge %0d: got %b, required none",
                         edge_n, btn_pulse);
            end else begin
                e = pq.pop_front();
                if (e.cyc != edge_n || e.val !== btn_pulse) begin
                    errors++;
                    $display("FAIL pulse at edge %0d: got %b, required %b at edge %0d",
                             edge_n, btn_pulse, e.val, e.cyc);
                end
            end
        end
        if (lq.size() != 0 && lq[0].cyc == edge_n) begin
            e = lq.pop_front();
            checks++;
            if (btn_level !== e.val) begin
                errors++;
                $display("FAIL level at edge %0d: got %b, required %b",
                         edge_n, btn_level, e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        btn_raw = 3'b000;
        wait_to(1);
        chk("reset_pulse", btn_pulse, 3'b000);
        chk("reset_level", btn_level, 3'b000);
        wait_to(2);
        reset = 1'b0;

        // Clean press on faster, first sampled at edge 10.
        push_p(16, 3'b001);
`ifdef BTN_AUTOREPEAT_EN
        push_p(36, 3'b001);
`endif
        push_l(15, 3'b000);
        push_l(16, 3'b001);
        push_l(45, 3'b001);
        push_l(46, 3'b000);
        wait_to(9);
        btn_raw[0] = 1'b1;
        wait_to(39);
        btn_raw[0] = 1'b0;

        // Bouncing next button; final rising sample at edge 55.
        push_p(61, 3'b100);
        push_l(60, 3'b000);
        push_l(61, 3'b100);
        push_l(76, 3'b100);
        push_l(77, 3'b000);
        wait_to(50);
        btn_raw[2] = 1'b1;
        wait_to(51);
        btn_raw[2] = 1'b0;
        wait_to(52);
        btn_raw[2] = 1'b1;
        wait_to(53);
        btn_raw[2] = 1'b0;
        wait_to(54);
        btn_raw[2] = 1'b1;
        wait_to(70);
        btn_raw[2] = 1'b0;

        // Press, 2-cycle release glitch, then a real release at edge 100.
        push_p(86, 3'b001);
        push_l(85, 3'b000);
        push_l(86, 3'b001);
        push_l(93, 3'b001);
        push_l(94, 3'b001);
        push_l(95, 3'b001);
        push_l(105, 3'b001);
        push_l(106, 3'b000);
        wait_to(79);
        btn_raw[0] = 1'b1;
        wait_to(89);
        btn_raw[0] = 1'b0;
        wait_to(91);
        btn_raw[0] = 1'b1;
        wait_to(99);
        btn_raw[0] = 1'b0;

        // Faster and slower rise together.
        push_p(126, 3'b011);
        push_l(125, 3'b000);
        push_l(126, 3'b011);
        push_l(135, 3'b011);
        push_l(136, 3'b000);
        wait_to(119);
        btn_raw = 3'b011;
        wait_to(129);
        btn_raw = 3'b000;

        // Reset while slower is in PRESS_WAIT with cnt=3, held through it.
        push_p(153, 3'b010);
        push_l(152, 3'b000);
        push_l(153, 3'b010);
        push_l(165, 3'b010);
        push_l(166, 3'b000);
        wait_to(139);
        btn_raw[1] = 1'b1;
        wait_to(144);
        reset = 1'b1;
        wait_to(145);
        chk("midreset_pulse", btn_pulse, 3'b000);
        chk("midreset_level", btn_level, 3'b000);
        wait_to(146);
        chk("midreset_level2", btn_level, 3'b000);
        reset = 1'b0;
        wait_to(159);
        btn_raw[1] = 1'b0;

        // Long hold on next: repeats only when the feature is built in.
        push_p(176, 3'b100);
`ifdef BTN_AUTOREPEAT_EN
        push_p(196, 3'b100);
        push_p(204, 3'b100);
        push_p(212, 3'b100);
        push_p(220, 3'b100);
        push_p(228, 3'b100);
`endif
        push_l(175, 3'b000);
        push_l(176, 3'b100);
        push_l(235, 3'b100);
        push_l(236, 3'b000);
        wait_to(169);
        btn_raw[2] = 1'b1;
        wait_to(229);
        btn_raw[2] = 1'b0;

        wait_to(250);
        checks++;
        if (pq.size() != 0) begin
            errors++;
            $display("FAIL pulses_missing: %0d outstanding, required 0",
                     pq.size());
        end
        checks++;
        if (lq.size() != 0) begin
            errors++;
            $display("FAIL levels_unchecked: %0d outstanding, required 0",
                     lq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
